// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared definitions for the boot-time memory loader.
//   ld_state_t : loader FSM state encoding
//   TGT_IMEM / TGT_DMEM : target-select byte codes at the head of a load stream
// Build option MEM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package riscv_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_TGT    = 4'd1,
      ST_CNT_LO = 4'd2,
      ST_CNT_HI = 4'd3,
      ST_DATA   = 4'd4,
      ST_WRITE  = 4'd5,
`ifdef MEM_LOADER_CHECKSUM_EN
      ST_CSUM   = 4'd6,
`endif
      ST_DONE   = 4'd7,
      ST_ERR    = 4'd8
   } ld_state_t;

   localparam logic [7:0] TGT_IMEM = 8'h00;
   localparam logic [7:0] TGT_DMEM = 8'h01;

endpackage

// File: rtl/mem_loader.sv
// mem_loader -- streams a program/data image from a byte channel into the
// instruction or data memory while holding the core in reset.
//
// Stream format: target byte (00=IMEM, 01=DMEM), 16-bit little-endian word
// count, then count*4 data bytes (little-endian words). With the build macro
// MEM_LOADER_CHECKSUM_EN a final byte equal to the XOR of all data bytes
// follows; without it the session ends after the last word write.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : one-cycle pulse, begins a session from IDLE/DONE/ERR
//   s_data     : stream byte
//   s_valid    : stream byte valid
//   s_ready    : loader accepts a byte this cycle
//   imem_we    : instruction-memory word write strobe
//   dmem_we    : data-memory word write strobe
//   mem_addr   : word address of the current write
//   mem_wdata  : assembled write word
//   core_hold  : keeps the core in reset (low only in DONE)
//   done       : session completed (held until next start)
//   err        : session aborted (held until next start)
module mem_loader
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              imem_we,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              err
);

   // Largest legal word count is the full memory depth.
   localparam logic [16:0] MAX_CNT = 17'(2 ** ADDR_W);

   // State entered once all words are written (or when count is zero).
`ifdef MEM_LOADER_CHECKSUM_EN
   localparam ld_state_t FIN_ST = ST_CSUM;
`else
   localparam ld_state_t FIN_ST = ST_DONE;
`endif

   ld_state_t         state, state_nx;
   logic [7:0]        cnt_lo;
   logic [15:0]       remain;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [1:0]        byte_idx;
   logic              tgt_dmem;
`ifdef MEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   logic        xfer;
   logic        sess_go;
   logic [15:0] cnt_full;

   assign xfer     = s_valid & s_ready;
   assign cnt_full = {s_data, cnt_lo};
   // A start is only honoured from a resting state.
   assign sess_go  = start & ((state == ST_IDLE) | (state == ST_DONE) | (state == ST_ERR));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      s_ready  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nx = ST_TGT;
         end
         ST_TGT: begin
            s_ready = 1'b1;
            if (xfer) begin
               if (s_data == TGT_IMEM || s_data == TGT_DMEM) state_nx = ST_CNT_LO;
               else                                          state_nx = ST_ERR;
            end
         end
         ST_CNT_LO: begin
            s_ready = 1'b1;
            if (xfer) state_nx = ST_CNT_HI;
         end
         ST_CNT_HI: begin
            s_ready = 1'b1;
            if (xfer) begin
               if ({1'b0, cnt_full} > MAX_CNT) state_nx = ST_ERR;
               else if (cnt_full == 16'd0)     state_nx = FIN_ST;
               else                            state_nx = ST_DATA;
            end
         end
         ST_DATA: begin
            s_ready = 1'b1;
            if (xfer && byte_idx == 2'd3) state_nx = ST_WRITE;
         end
         ST_WRITE: begin
            if (remain == 16'd1) state_nx = FIN_ST;
            else                 state_nx = ST_DATA;
         end
`ifdef MEM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            s_ready = 1'b1;
            if (xfer) state_nx = (s_data == csum) ? ST_DONE : ST_ERR;
         end
`endif
         ST_DONE: begin
            if (start) state_nx = ST_TGT;
         end
         ST_ERR: begin
            if (start) state_nx = ST_TGT;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_lo   <= 8'h00;
         remain   <= 16'h0000;
         addr     <= '0;
         wdata    <= 32'h0;
         byte_idx <= 2'd0;
         tgt_dmem <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
         csum     <= 8'h00;
`endif
      end else if (sess_go) begin
         cnt_lo   <= 8'h00;
         remain   <= 16'h0000;
         addr     <= '0;
         wdata    <= 32'h0;
         byte_idx <= 2'd0;
         tgt_dmem <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
         csum     <= 8'h00;
`endif
      end else begin
         case (state)
            ST_TGT:    if (xfer) tgt_dmem <= (s_data == TGT_DMEM);
            ST_CNT_LO: if (xfer) cnt_lo <= s_data;
            ST_CNT_HI: if (xfer) remain <= cnt_full;
            ST_DATA: begin
               if (xfer) begin
                  // Bytes of the previous word are overwritten in place;
                  // the full word is stable through the WRITE cycle.
                  wdata[{byte_idx, 3'b000} +: 8] <= s_data;
                  byte_idx <= byte_idx + 2'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
                  csum <= csum ^ s_data;
`endif
               end
            end
            ST_WRITE: begin
               remain <= remain - 16'd1;
               // Hold the address on the final word so a full-depth load
               // leaves mem_addr at the last location instead of wrapping.
               if (remain != 16'd1) addr <= addr + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign imem_we   = (state == ST_WRITE) & ~tgt_dmem;
   assign dmem_we   = (state == ST_WRITE) &  tgt_dmem;
   assign mem_addr  = addr;
   assign mem_wdata = wdata;
   assign core_hold = (state != ST_DONE);
   assign done      = (state == ST_DONE);
   assign err       = (state == ST_ERR);

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader -- randomized self-checking bench for mem_loader.
// Expected write lists and outcomes come from a stream-parsing model;
// build with MEM_LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_mem_loader;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        s_data = 8'h00;
   logic              s_valid = 1'b0;
   logic              s_ready, imem_we, dmem_we, core_hold, done, err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   mem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .s_data(s_data),
      .s_valid(s_valid), .s_ready(s_ready), .imem_we(imem_we),
      .dmem_we(dmem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_hold(core_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              d;
      logic [ADDR_W-1:0] a;
      logic [31:0]       w;
   } wr_t;

   wr_t        act[$];
   wr_t        exq[$];
   logic [7:0] st[$];
   int         vec = 0;
   int         mis = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec++;
      if (got !== exp) begin
         mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Write monitor: sampled mid-cycle.
   always @(negedge clk) begin
      if (imem_we || dmem_we) begin
         if (imem_we && dmem_we) chk("we_excl", 1, 0);
         act.push_back('{d: dmem_we, a: mem_addr, w: mem_wdata});
      end
   end

   // Reference: parse the stream into expected writes and an outcome.
   task automatic model(output bit ok, output int used);
      int         cnt;
      logic [7:0] cs;
      logic [7:0] b0;
      exq.delete();
      cs = 8'h00;
      b0 = st[0];
      if (b0 > 8'h01) begin ok = 0; used = 1; return; end
      cnt = int'(st[1]) + 256 * int'(st[2]);
      if (cnt > 2 ** ADDR_W) begin ok = 0; used = 3; return; end
      for (int k = 0; k < cnt; k++) begin
         exq.push_back('{d: b0[0], a: ADDR_W'(k),
                         w: {st[3+4*k+3], st[3+4*k+2], st[3+4*k+1], st[3+4*k]}});
         for (int j = 0; j < 4; j++) cs = cs ^ st[3+4*k+j];
      end
      used = 3 + 4 * cnt;
      ok   = 1;
`ifdef MEM_LOADER_CHECKSUM_EN
      used++;
      ok = (st[used-1] == cs);
`endif
   endtask

   task automatic add_csum();
`ifdef MEM_LOADER_CHECKSUM_EN
      logic [7:0] cs;
      int         cnt;
      cs  = 8'h00;
      cnt = int'(st[1]) + 256 * int'(st[2]);
      for (int i = 3; i < 3 + 4 * cnt; i++) cs = cs ^ st[i];
      st.push_back(cs);
`endif
   endtask

   task automatic build(input logic [7:0] tgt, input int cnt);
      st.delete();
      st.push_back(tgt);
      st.push_back(cnt[7:0]);
      st.push_back(cnt[15:8]);
      for (int i = 0; i < 4 * cnt; i++) st.push_back(8'($urandom));
      add_csum();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int gap, n;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if (gap > 0) begin
         s_valid = 1'b0;
         s_data  = 8'($urandom);
         repeat (gap) @(posedge clk);
         #1;
      end
      s_valid = 1'b1;
      s_data  = b;
      n = 0;
      forever begin
         @(negedge clk);
         if (s_ready) begin
            @(posedge clk); #1;
            break;
         end
         n++;
         if (n > 200) begin
            chk("byte_timeout", 0, 1);
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic run_session(input string tag);
      bit ok;
      int used, n, m;
      model(ok, used);
      act.delete();
      pulse_start();
      chk({tag, "_start_clr"}, {done, err}, 2'b00);
      for (int i = 0; i < used; i++) send_byte(st[i]);
      n = 0;
      while (!(done || err) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ended"}, done | err, 1);
      chk({tag, "_done"}, done, ok);
      chk({tag, "_err"}, err, !ok);
      chk({tag, "_hold"}, core_hold, !ok);
      chk({tag, "_ready"}, s_ready, 0);
      chk({tag, "_nwr"}, act.size(), exq.size());
      m = (act.size() < exq.size()) ? act.size() : exq.size();
      for (int i = 0; i < m; i++) chk({tag, "_wr"}, act[i], exq[i]);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, s_ready, 0);
      chk({tag, "_iwe"}, imem_we, 0);
      chk({tag, "_dwe"}, dmem_we, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_hold"}, core_hold, 1);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   initial begin
      int n_before;
      repeat (3) @(posedge clk);
      chk_idle("rst");
      #1 reset = 1'b1;
      @(posedge clk); #1;
      chk_idle("idle");

      // Two-word IMEM image.
      st = '{8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
      add_csum();
      run_session("imem2");

      // Single DMEM word.
      st = '{8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      add_csum();
      run_session("dmem1");

      // Bad target, then recovery.
      st = '{8'h05};
      run_session("badtgt");
      build(8'h00, 3);
      run_session("recover");

      // Count boundaries.
      st = '{8'h00, 8'h01, 8'h04};
      run_session("cnt401");
      build(8'h00, 0);
      run_session("cnt0");
      build(8'h01, 1024);
      run_session("cnt400");
      chk("cnt400_last", mem_addr, 10'h3FF);

      // Random sessions.
      for (int r = 0; r < 8; r++) begin
         logic [7:0] t;
         t = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
         build(t, $urandom_range(0, 6));
         run_session("rnd");
      end

`ifdef MEM_LOADER_CHECKSUM_EN
      st = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
      run_session("csum_ok");
      st = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
      run_session("csum_bad");
`endif

      // Reset in the middle of the second word.
      build(8'h00, 4);
      act.delete();
      pulse_start();
      for (int i = 0; i < 3 + 5; i++) send_byte(st[i]);
      n_before = act.size();
      chk("mid_wr_before", n_before, 1);
      #2 reset = 1'b0;
      #1 chk_idle("mid_rst");
      @(posedge clk); #3;
      reset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         s_valid = 1'($urandom);
         s_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      @(negedge clk);
      chk("mid_no_wr", act.size(), n_before);
      chk("mid_ready", s_ready, 0);
      chk("mid_hold", core_hold, 1);
      chk("mid_flags", {done, err}, 2'b00);
      build(8'h01, 2);
      run_session("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of each target memory (depth 2**ADDR_W words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately.
REQ-004 start  input  1  single-cycle pulse; begins a load session.
REQ-005 s_data  input  8  byte stream data.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_ready  output  1  loader accepts a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory word write strobe.
REQ-009 dmem_we  output  1  data-memory word write strobe.
REQ-010 mem_addr  output  ADDR_W  word address of the current write.
REQ-011 mem_wdata  output  32  assembled write word.
REQ-012 core_hold  output  1  holds the pipeline in reset while high.
REQ-013 done  output  1  load completed successfully; sticky.
REQ-014 err  output  1  load aborted; sticky.

Function
REQ-015 A byte SHALL transfer only on a clock edge where s_valid=1 and s_ready=1.
REQ-016 States: IDLE, TGT, CNT_LO, CNT_HI, DATA, WRITE, [CSUM], DONE, ERR.
REQ-017 IDLE: s_ready=0; start -> TGT; a start in any other state except DONE/ERR SHALL be ignored.
REQ-018 TGT: accepted byte 0x00 selects IMEM, 0x01 selects DMEM, any other value -> ERR.
REQ-019 CNT_LO/CNT_HI: 16-bit word count, little-endian; count > 2**ADDR_W -> ERR; count = 0 -> DONE (or CSUM when enabled).
REQ-020 DATA: s_ready=1; bytes assembled little-endian (first byte -> bits 7:0); 4th byte -> WRITE.
REQ-021 WRITE: exactly one cycle; s_ready=0; selected we=1, mem_addr=current address, mem_wdata=assembled word; the other we stays 0.
REQ-022 Address starts at 0 each session and increments by 1 after each WRITE; the last write of count N SHALL be at address N-1, with no wrap.
REQ-023 After WRITE: remaining words > 0 -> DATA; otherwise -> DONE (or CSUM).
REQ-024 DONE: done=1, core_hold=0, s_ready=0; start -> TGT, clearing done.
REQ-025 ERR: err=1, core_hold=1, s_ready=0, no writes; start -> TGT, clearing err.
REQ-026 core_hold SHALL be 1 in every state except DONE.
REQ-027 Gaps in s_valid SHALL stall the FSM without losing assembled bytes.

Reset
REQ-028 While reset=0: state IDLE, s_ready=0, imem_we=0, dmem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, done=0, err=0, and internal counters cleared.
REQ-029 Reset asserted mid-session SHALL abandon the session with no further write strobes; release SHALL return to IDLE.

Configuration
REQ-030 Macro MEM_LOADER_CHECKSUM_EN defined: after the last word, state CSUM accepts one byte; it must equal the XOR of all data bytes (initial value 0x00); match -> DONE, mismatch -> ERR. Words already written remain written.
REQ-031 Macro MEM_LOADER_CHECKSUM_EN undefined: no CSUM state, no checksum byte; last WRITE -> DONE.

Structure
REQ-032 The shared package riscv_pkg SHALL hold the loader state enum and the target codes TGT_IMEM=8'h00 and TGT_DMEM=8'h01.
REQ-033 No sub-module is required; the FSM, byte assembler and counters reside in mem_loader.

Verification
REQ-034 Reset, then start, then stream 00,02,00,13,00,00,00,93,00,10,00 -> imem_we pulses at addr 0 (0x00000013) and addr 1 (0x00100093); done=1; core_hold falls.
REQ-035 Target byte 0x01 with count 1 and word 0xDEADBEEF -> dmem_we=1 at addr 0 with 0xDEADBEEF; imem_we never asserts.
REQ-036 Target byte 0x05 -> err=1, core_hold=1, no write strobes; a following start with a valid stream -> done=1.
REQ-037 Count 0x0401 with ADDR_W=10 -> ERR; count 0x0400 -> 1024 writes, last at addr 0x3FF.
REQ-038 Random s_valid gaps and reset pulsed low after the 5th data byte -> no strobe after reset; state IDLE; core_hold=1.
REQ-039 With MEM_LOADER_CHECKSUM_EN, count 1, word bytes 01,02,04,08, checksum byte 0x0F -> done=1; checksum byte 0x0E -> err=1.
